// File: rtl/dd_arbiter.sv
// Round-robin arbiter that shares one DoubleDabble binary-to-BCD converter among
// NREQ requesters, with a busy-cycle timeout that aborts a stuck conversion.
module dd_arbiter #(
   parameter int N       = 32,
   parameter int NREQ    = 4,
   parameter int DIGITS  = (N + 2) / 3,
   parameter int TIMEOUT = 4 * N
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req_i,
   input  logic [NREQ-1:0][N-1:0]    req_v_i,
   output logic [NREQ-1:0]           ack_o,
   output logic [NREQ-1:0]           err_o,
   output logic [4*DIGITS-1:0]       result_o,
   output logic                      busy_o,
   output logic                      dd_start_o,
   output logic [N-1:0]              dd_v_o,
   input  logic [4*DIGITS-1:0]       dd_bcd_i,
   input  logic                      dd_ready_i
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_DELIVER
   } state_e;

   state_e              state_q, state_d;
   logic [IW-1:0]       winner_q, winner_d;
   logic [IW-1:0]       last_q, last_d;
   logic [N-1:0]        dd_v_q, dd_v_d;
   logic [4*DIGITS-1:0] result_q, result_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic                seen_q, seen_d;

   logic                rr_found;
   logic [IW-1:0]       rr_pick;
   logic [IW-1:0]       rr_cand;

   // Search starts one past the last granted index and wraps modulo NREQ.
   always_comb begin
      rr_found = 1'b0;
      rr_pick  = '0;
      rr_cand  = '0;
      for (int k = 0; k < NREQ; k++) begin
         rr_cand = IW'((int'(last_q) + 1 + k) % NREQ);
         if (!rr_found && req_i[rr_cand]) begin
            rr_found = 1'b1;
            rr_pick  = rr_cand;
         end
      end
   end

   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can infer a latch.
      state_d  = state_q;
      winner_d = winner_q;
      last_d   = last_q;
      dd_v_d   = dd_v_q;
      result_d = result_q;
      cnt_d    = cnt_q;
      seen_d   = seen_q;
      ack_o    = '0;
      err_o    = '0;

      case (state_q)
         S_IDLE: begin
            if (rr_found && dd_ready_i) begin
               winner_d = rr_pick;
               dd_v_d   = req_v_i[rr_pick];
               state_d  = S_LAUNCH;
            end
         end
         S_LAUNCH: begin
            seen_d  = 1'b0;
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // Ready only counts as completion once the converter has been seen busy.
            seen_d = seen_q | ~dd_ready_i;
            if (dd_ready_i && seen_q) begin
               result_d = dd_bcd_i;
               state_d  = S_DELIVER;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               err_o[winner_q] = 1'b1;
               last_d          = winner_q;
               state_d         = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DELIVER: begin
            ack_o[winner_q] = req_i[winner_q];
            last_d          = winner_q;
            state_d         = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         winner_q <= '0;
         last_q   <= IW'(NREQ - 1);
         dd_v_q   <= '0;
         result_q <= '0;
         cnt_q    <= '0;
         seen_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         winner_q <= winner_d;
         last_q   <= last_d;
         dd_v_q   <= dd_v_d;
         result_q <= result_d;
         cnt_q    <= cnt_d;
         seen_q   <= seen_d;
      end
   end

   assign busy_o     = (state_q != S_IDLE);
   assign dd_start_o = (state_q == S_LAUNCH);
   assign dd_v_o     = dd_v_q;
   assign result_o   = result_q;

endmodule

// File: doc/dd_arbiter.md
DD_ARBITER -- requirements
Module: dd_arbiter

Interface
REQ-001 Parameter N, default 32: binary operand width per requester.
REQ-002 Parameter NREQ, default 4: number of requesters, 2..8.
REQ-003 Parameter DIGITS, default (N+2)/3: BCD digit count; result width is 4*DIGITS.
REQ-004 Parameter TIMEOUT, default 4*N: maximum converter busy cycles before abort.
REQ-005 Clock  in  1  single clock; all state updates on rising edge.
REQ-006 Reset  in  1  asynchronous, active-low reset.
REQ-007 Req  in  NREQ  per-requester conversion request, level, held until Ack or withdrawal.
REQ-008 ReqV  in  NREQ x N  per-requester binary operand, stable while Req[i] high.
REQ-009 Ack  out  NREQ  one-cycle pulse; Result valid for requester i that cycle.
REQ-010 Err  out  NREQ  one-cycle pulse; requester i conversion aborted by timeout.
REQ-011 Result  out  4*DIGITS  BCD result, digit 0 in bits [3:0].
REQ-012 Busy  out  1  high in any state other than IDLE.
REQ-013 DdStart  out  1  one-cycle start pulse to the shared DoubleDabble converter.
REQ-014 DdV  out  N  operand to converter, registered, stable from DdStart through completion.
REQ-015 DdBCD  in  4*DIGITS  converter result, valid when DdReady high after completion.
REQ-016 DdReady  in  1  converter idle/done; converter drops it the cycle after sampling DdStart.

Function
REQ-017 FSM states SHALL be IDLE, LAUNCH, WAIT, DELIVER; encoding is implementation choice.
REQ-018 IDLE: if any Req bit high and DdReady high, SHALL select winner by round-robin, latch ReqV[winner] into DdV and winner index, go LAUNCH.
REQ-019 Round-robin: search starts at index (last granted + 1) mod NREQ; after reset search starts at 0.
REQ-020 LAUNCH: DdStart SHALL be high for exactly this one cycle; clear busy-seen flag and timeout counter; go WAIT.
REQ-021 WAIT: busy-seen flag SHALL set when DdReady sampled low; completion = DdReady high with busy-seen set.
REQ-022 WAIT on completion: latch DdBCD into Result register, go DELIVER.
REQ-023 DELIVER: if Req[winner] still high, Ack[winner] SHALL pulse this cycle; update last-granted to winner; go IDLE.
REQ-024 Request withdrawn (Req[winner] low) in DELIVER: no Ack, Result still updated, last-granted still updated, go IDLE.
REQ-025 Withdrawal during LAUNCH/WAIT SHALL NOT abort the converter; arbiter completes cycle per REQ-024.
REQ-026 Timeout counter SHALL increment each WAIT cycle; reaching TIMEOUT without completion: Err[winner] pulse, last-granted = winner, go IDLE, Result unchanged.
REQ-027 Ack and Err SHALL be mutually exclusive and at most one bit high per cycle.
REQ-028 Minimum latency IDLE-grant to Ack = 3 + converter busy cycles; back-to-back grant allowed the cycle after DELIVER.
REQ-029 Req bits rising while not IDLE SHALL be held pending, never dropped, never Acked without a full conversion.
REQ-030 Result SHALL hold its value between conversions; ReqV changes after latch SHALL NOT affect DdV.

Reset
REQ-031 Reset low SHALL immediately force IDLE, DdStart=0, Ack=0, Err=0, Busy=0, DdV=0, Result=0, last-granted=NREQ-1, counters 0.
REQ-032 Reset mid-conversion SHALL discard the job; no Ack/Err for it after release; first post-reset grant goes to lowest requesting index.
REQ-033 Reset release SHALL be treated synchronously; first grant no earlier than the first rising edge with Reset high.

Verification
REQ-034 Req[0]=1, ReqV[0]=255, behavioural converter -> single DdStart pulse, DdV=255, Ack[0] pulse, Result digits 0255 (upper zero).
REQ-035 Req[2]=1, ReqV[2]=4294967295 -> Ack[2], Result digits 4294967295, Busy low cycle after Ack.
REQ-036 Req=4'b1111 held, operands 1,2,3,4 -> Acks in order 0,1,2,3,0 with Results 1,2,3,4,1; one DdStart per grant.
REQ-037 Converter model never returns DdReady, TIMEOUT=128 -> Err[winner] 128 WAIT cycles after LAUNCH, no Ack, next requester granted.
REQ-038 Req[1] dropped during WAIT -> no Ack[1], Req[3] pending granted next; Reset low during WAIT -> all outputs 0 same cycle, no stale Ack after release.
